// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: opcodes and the
// decode-to-execute control bundle.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic [6:0] opcode;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard compare between the decode slot and the
// load currently sitting in EX.
module hazard_detect_unit
  import riscv_pkg::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  logic uses_rs1;
  logic uses_rs2;
  logic hit_rs1;
  logic hit_rs2;

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (id_opcode)
      OP_LUI, OP_AUIPC, OP_JAL: uses_rs1 = 1'b0;
      OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign hit_rs1 = uses_rs1 & (ex_rd == id_rs1);
  assign hit_rs2 = uses_rs2 & (ex_rd == id_rs2);

  // x0 is never a real producer, so a load to x0 never stalls
  assign hazard = id_valid & ex_valid & ex_mem_read
                & (ex_rd != 5'd0)
                & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, bubble
// insertion and branch squash.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic            id_reg_write,
  input  logic            id_alu_src,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_mem_read,
  input  logic            id_mem_to_reg,
  input  logic [1:0]      id_alu_op,
  input  logic [6:0]      id_opcode,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            hold,
  input  logic            flush,
  output logic            ex_valid,
  output logic            ex_reg_write,
  output logic            ex_alu_src,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_mem_read,
  output logic            ex_mem_to_reg,
  output logic [1:0]      ex_alu_op,
  output logic [6:0]      ex_opcode,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7_5,
  output logic            stall_fd,
  output logic [31:0]     load_use_count
);

  ctrl_t id_ctrl;
  ctrl_t pass_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  bubble;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    alu_src:    id_alu_src,
    mem_write:  id_mem_write,
    branch:     id_branch,
    mem_read:   id_mem_read,
    mem_to_reg: id_mem_to_reg,
    alu_op:     id_alu_op,
    opcode:     id_opcode
  };

  // an empty decode slot must never carry live control into EX
  assign pass_ctrl = id_valid ? id_ctrl : CTRL_BUBBLE;

  hazard_detect_unit u_hdu (
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rd       (ex_rd),
    .hazard      (hazard)
  );

  assign bubble   = flush | hazard;
  assign stall_fd = hazard & ~flush & ~hold & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_ctrl        <= CTRL_BUBBLE;
      ex_pc          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_funct7_5    <= 1'b0;
      load_use_count <= '0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= CTRL_BUBBLE;
        ex_pc       <= '0;
        ex_rs1_data <= '0;
        ex_rs2_data <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7_5 <= 1'b0;
        if (!flush)
          load_use_count <= load_use_count + 32'd1;
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= pass_ctrl;
        ex_pc       <= id_pc;
        ex_rs1_data <= id_rs1_data;
        ex_rs2_data <= id_rs2_data;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct3   <= id_funct3;
        ex_funct7_5 <= id_funct7_5;
      end
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_alu_op     = ex_ctrl.alu_op;
  assign ex_opcode     = ex_ctrl.opcode;

endmodule
